// File: rtl/z2_autoconfig_pkg.sv
// rtl/z2_autoconfig_pkg.sv - shared constants, types and helpers for the Zorro II autoconfig host
//   Register indices (word offsets inside $E8xxxx), size-code enum,
//   size-code-to-MB decode, ID register walk order, FSM state types.
package z2_autoconfig_pkg;

  localparam logic [7:0] AC_SPACE    = 8'hE8;
  localparam logic [7:0] REG_TYPE    = 8'h00;
  localparam logic [7:0] REG_SIZE    = 8'h01;
  localparam logic [7:0] REG_PROD_HI = 8'h02;
  localparam logic [7:0] REG_PROD_LO = 8'h03;
  localparam logic [7:0] REG_MFG_0   = 8'h08;
  localparam logic [7:0] REG_MFG_1   = 8'h09;
  localparam logic [7:0] REG_MFG_2   = 8'h0A;
  localparam logic [7:0] REG_MFG_3   = 8'h0B;
  localparam logic [7:0] REG_BASE    = 8'h24;
  localparam logic [7:0] REG_SHUTUP  = 8'h26;

  typedef enum logic [2:0] {
    SZ_8MB = 3'b000,
    SZ_4MB = 3'b111,
    SZ_2MB = 3'b110,
    SZ_1MB = 3'b101
  } size_code_e;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_TYPE, S_RD_SIZE, S_RD_ID, S_ALLOC,
    S_WR_BASE, S_WR_SHUT, S_REPORT, S_FIN
  } host_state_e;

  typedef enum logic [2:0] {
    B_IDLE, B_SETUP, B_STROBE, B_WAIT, B_RELEASE
  } bus_state_e;

  // Board size in MB; 0 marks a code this host cannot place.
  function automatic logic [3:0] size_to_mb(input logic [2:0] code);
    case (code)
      SZ_8MB:  size_to_mb = 4'd8;
      SZ_4MB:  size_to_mb = 4'd4;
      SZ_2MB:  size_to_mb = 4'd2;
      SZ_1MB:  size_to_mb = 4'd1;
      default: size_to_mb = 4'd0;
    endcase
  endfunction

  // ID registers in capture order: product hi/lo, then manufacturer MSB first.
  function automatic logic [7:0] id_reg(input logic [2:0] idx);
    case (idx)
      3'd0:    id_reg = REG_PROD_HI;
      3'd1:    id_reg = REG_PROD_LO;
      3'd2:    id_reg = REG_MFG_0;
      3'd3:    id_reg = REG_MFG_1;
      3'd4:    id_reg = REG_MFG_2;
      default: id_reg = REG_MFG_3;
    endcase
  endfunction

endpackage

// File: rtl/z2_bus_cycle.sv
// rtl/z2_bus_cycle.sv - one 68000-style nibble bus cycle in autoconfig space with DTACK timeout
//   CLK, RESETn          : clock, synchronous active-low reset
//   req, rw, reg_idx,    : cycle request (accepted when idle), rw=1 read,
//   wdata                  register word offset, write nibble
//   ack, rdata, timeout  : ack pulses in RELEASE; rdata/timeout valid with it
//   ADDR, DBUS_*, ASn,   : bus side (A23:1, D15:12, strobes, acknowledge)
//   UDSn, LDSn, RWn, DTACKn
import z2_autoconfig_pkg::*;

module z2_bus_cycle #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        req,
  input  logic        rw,
  input  logic [7:0]  reg_idx,
  input  logic [3:0]  wdata,
  output logic        ack,
  output logic [3:0]  rdata,
  output logic        timeout,
  output logic [22:0] ADDR,
  output logic [3:0]  DBUS_OUT,
  output logic        DBUS_OE,
  input  logic [3:0]  DBUS_IN,
  output logic        ASn,
  output logic        UDSn,
  output logic        LDSn,
  output logic        RWn,
  input  logic        DTACKn
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  bus_state_e    state, state_nx;
  logic [22:0]   addr_q;
  logic          rw_q;
  logic [3:0]    wdata_q;
  logic [3:0]    rdata_q;
  logic          to_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state   <= B_IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
      to_q    <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        B_IDLE: if (req) begin
          addr_q  <= {AC_SPACE, 7'b0, reg_idx};
          rw_q    <= rw;
          wdata_q <= wdata;
          to_q    <= 1'b0;
        end
        B_STROBE: cnt <= '0;
        B_WAIT: begin
          if (!DTACKn) begin
            if (rw_q) rdata_q <= DBUS_IN;
          end else if (cnt == TO_LAST) begin
            to_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      B_IDLE:    if (req) state_nx = B_SETUP;
      B_SETUP:   state_nx = B_STROBE;
      B_STROBE:  state_nx = B_WAIT;
      B_WAIT:    if (!DTACKn || cnt == TO_LAST) state_nx = B_RELEASE;
      B_RELEASE: state_nx = B_IDLE;
      default:   state_nx = B_IDLE;
    endcase
  end

  // Strobes and data drive come straight from state so RELEASE/reset
  // deassert everything in the same cycle.
  logic active, strobe;
  always_comb begin
    active   = state inside {B_SETUP, B_STROBE, B_WAIT};
    strobe   = state inside {B_STROBE, B_WAIT};
    ADDR     = addr_q;
    DBUS_OUT = wdata_q;
    DBUS_OE  = active && !rw_q;
    RWn      = active ? rw_q : 1'b1;
    ASn      = !strobe;
    UDSn     = !strobe;
    LDSn     = 1'b1;
    ack      = (state == B_RELEASE);
    rdata    = rdata_q;
    timeout  = to_q;
  end

endmodule

// File: rtl/z2_autoconfig_host.sv
// rtl/z2_autoconfig_host.sv - Zorro II autoconfig initiator: enumerate boards, place memory, report
//   CLK, RESETn, start   : clock, sync active-low reset, enumeration start pulse
//   ADDR..DTACKn         : 68000 bus toward the autoconfig chain
//   busy, done           : enumeration in progress / one-cycle end pulse
//   rpt_*                : per-board report, valid/ready handshake
//   board_count          : boards handshaken so far
//   Macro AUTOCFG_ID_READ_EN adds product/manufacturer reads and rpt_prod/rpt_mfg.
import z2_autoconfig_pkg::*;

module z2_autoconfig_host #(
  parameter logic [3:0] FREE_BASE  = 4'h2,
  parameter logic [3:0] FREE_END   = 4'hA,
  parameter int         TIMEOUT    = 64,
  parameter int         MAX_BOARDS = 8
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        start,
  output logic [22:0] ADDR,
  output logic [3:0]  DBUS_OUT,
  output logic        DBUS_OE,
  input  logic [3:0]  DBUS_IN,
  output logic        ASn,
  output logic        UDSn,
  output logic        LDSn,
  output logic        RWn,
  input  logic        DTACKn,
  output logic        busy,
  output logic        done,
  output logic        rpt_valid,
  input  logic        rpt_ready,
  output logic [3:0]  rpt_base,
  output logic [2:0]  rpt_size,
  output logic        rpt_shutup,
  output logic [3:0]  board_count
`ifdef AUTOCFG_ID_READ_EN
  ,
  output logic [7:0]  rpt_prod,
  output logic [15:0] rpt_mfg
`endif
);

  localparam logic [3:0] LAST_BOARD = 4'(MAX_BOARDS - 1);

  host_state_e state, state_nx;
  logic        bus_req, bus_rw, bus_ack, bus_timeout;
  logic [7:0]  bus_reg;
  logic [3:0]  bus_wdata, bus_rdata;

  logic [2:0]  type_q;
  logic [2:0]  size_q;
  logic [3:0]  base_q;
  logic        shut_q;
  logic [4:0]  next_free;   // 5 bits so base+size never wraps past 4'hF
`ifdef AUTOCFG_ID_READ_EN
  logic [2:0]  id_idx;
  logic [7:0]  prod_q;
  logic [15:0] mfg_q;
`endif

  z2_bus_cycle #(.TIMEOUT(TIMEOUT)) u_bus (
    .CLK(CLK), .RESETn(RESETn),
    .req(bus_req), .rw(bus_rw), .reg_idx(bus_reg), .wdata(bus_wdata),
    .ack(bus_ack), .rdata(bus_rdata), .timeout(bus_timeout),
    .ADDR(ADDR), .DBUS_OUT(DBUS_OUT), .DBUS_OE(DBUS_OE), .DBUS_IN(DBUS_IN),
    .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn), .DTACKn(DTACKn)
  );

  // Placement: align to min(size,2)MB relative to FREE_BASE, then fit check.
  logic [3:0] mb;
  logic [4:0] off, base5, end5;
  logic       fits;
  always_comb begin
    mb  = size_to_mb(size_q);
    off = next_free - {1'b0, FREE_BASE};
    if (mb != 4'd1 && off[0]) off = off + 5'd1;
    base5 = {1'b0, FREE_BASE} + off;
    end5  = base5 + {1'b0, mb};
    fits  = (type_q == 3'b111) && (mb != 4'd0) && (end5 <= {1'b0, FREE_END});
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Bus requests are held for the whole state; the engine only takes one
  // when idle and the FSM leaves the state on the matching ack.
  always_comb begin
    state_nx  = state;
    bus_req   = 1'b0;
    bus_rw    = 1'b1;
    bus_reg   = REG_TYPE;
    bus_wdata = 4'h0;
    case (state)
      S_IDLE: if (start) state_nx = S_RD_TYPE;
      S_RD_TYPE: begin
        bus_req = 1'b1;
        if (bus_ack) state_nx = bus_timeout ? S_FIN : S_RD_SIZE;
      end
      S_RD_SIZE: begin
        bus_req = 1'b1;
        bus_reg = REG_SIZE;
`ifdef AUTOCFG_ID_READ_EN
        if (bus_ack) state_nx = S_RD_ID;
`else
        if (bus_ack) state_nx = S_ALLOC;
`endif
      end
      S_RD_ID: begin
`ifdef AUTOCFG_ID_READ_EN
        bus_req = 1'b1;
        bus_reg = id_reg(id_idx);
        if (bus_ack && id_idx == 3'd5) state_nx = S_ALLOC;
`else
        state_nx = S_ALLOC;
`endif
      end
      S_ALLOC: state_nx = fits ? S_WR_BASE : S_WR_SHUT;
      S_WR_BASE: begin
        bus_req   = 1'b1;
        bus_rw    = 1'b0;
        bus_reg   = REG_BASE;
        bus_wdata = base_q;
        if (bus_ack) state_nx = S_REPORT;
      end
      S_WR_SHUT: begin
        bus_req = 1'b1;
        bus_rw  = 1'b0;
        bus_reg = REG_SHUTUP;
        if (bus_ack) state_nx = S_REPORT;
      end
      S_REPORT: if (rpt_ready) state_nx = (board_count == LAST_BOARD) ? S_FIN : S_RD_TYPE;
      S_FIN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      type_q      <= '0;
      size_q      <= '0;
      base_q      <= '0;
      shut_q      <= 1'b0;
      next_free   <= {1'b0, FREE_BASE};
      board_count <= '0;
`ifdef AUTOCFG_ID_READ_EN
      id_idx      <= '0;
      prod_q      <= '0;
      mfg_q       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          next_free   <= {1'b0, FREE_BASE};
          board_count <= '0;
        end
        S_RD_TYPE: if (bus_ack) type_q <= bus_rdata[3:1];
        S_RD_SIZE: if (bus_ack) begin
          size_q <= bus_rdata[2:0];
`ifdef AUTOCFG_ID_READ_EN
          id_idx <= '0;
`endif
        end
`ifdef AUTOCFG_ID_READ_EN
        S_RD_ID: if (bus_ack) begin
          id_idx <= id_idx + 3'd1;
          case (id_idx)
            3'd0:    prod_q[7:4]  <= ~bus_rdata;
            3'd1:    prod_q[3:0]  <= ~bus_rdata;
            3'd2:    mfg_q[15:12] <= ~bus_rdata;
            3'd3:    mfg_q[11:8]  <= ~bus_rdata;
            3'd4:    mfg_q[7:4]   <= ~bus_rdata;
            default: mfg_q[3:0]   <= ~bus_rdata;
          endcase
        end
`endif
        S_ALLOC: begin
          if (fits) begin
            base_q    <= base5[3:0];
            shut_q    <= 1'b0;
            next_free <= end5;
          end else begin
            base_q    <= 4'h0;
            shut_q    <= 1'b1;
          end
        end
        S_REPORT: if (rpt_ready) board_count <= board_count + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = !(state inside {S_IDLE, S_FIN});
    done       = (state == S_FIN);
    rpt_valid  = (state == S_REPORT);
    rpt_base   = base_q;
    rpt_size   = size_q;
    rpt_shutup = shut_q;
`ifdef AUTOCFG_ID_READ_EN
    rpt_prod   = prod_q;
    rpt_mfg    = mfg_q;
`endif
  end

endmodule

// File: tb/tb_z2_autoconfig_host.sv
// tb/tb_z2_autoconfig_host.sv - randomized self-checking bench for z2_autoconfig_host
//   Emulates an autoconfig chain of boards and predicts placement from the allocation rules.
module tb_z2_autoconfig_host;

  logic        CLK = 1'b0;
  logic        RESETn, start, rpt_ready;
  logic [22:0] ADDR;
  logic [3:0]  DBUS_OUT;
  logic        DBUS_OE;
  logic [3:0]  DBUS_IN = 4'h0;
  logic        ASn, UDSn, LDSn, RWn;
  logic        DTACKn = 1'b1;
  logic        busy, done, rpt_valid, rpt_shutup;
  logic [3:0]  rpt_base, board_count;
  logic [2:0]  rpt_size;
`ifdef AUTOCFG_ID_READ_EN
  logic [7:0]  rpt_prod;
  logic [15:0] rpt_mfg;
`endif

  always #5 CLK = ~CLK;

  z2_autoconfig_host dut (
    .CLK(CLK), .RESETn(RESETn), .start(start),
    .ADDR(ADDR), .DBUS_OUT(DBUS_OUT), .DBUS_OE(DBUS_OE), .DBUS_IN(DBUS_IN),
    .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn), .DTACKn(DTACKn),
    .busy(busy), .done(done), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_base(rpt_base), .rpt_size(rpt_size), .rpt_shutup(rpt_shutup),
    .board_count(board_count)
`ifdef AUTOCFG_ID_READ_EN
    , .rpt_prod(rpt_prod), .rpt_mfg(rpt_mfg)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Board chain: board_ptr is the board currently answering in $E8xxxx.
  int          nb;
  logic [3:0]  b_type [16];
  logic [2:0]  b_size [16];
  logic        b_s3   [16];
  logic [7:0]  b_prod [16];
  logic [15:0] b_mfg  [16];
  int          board_ptr = 0;
  logic        hold_off;
  logic        clr_req, clr_seen = 1'b0;
  logic [7:0]  wlog_reg[$];
  logic [3:0]  wlog_dat[$];

  function automatic logic [3:0] reg_nib(input int b, input logic [7:0] r);
    case (r)
      8'h00:   reg_nib = b_type[b];
      8'h01:   reg_nib = {b_s3[b], b_size[b]};
      8'h02:   reg_nib = ~b_prod[b][7:4];
      8'h03:   reg_nib = ~b_prod[b][3:0];
      8'h08:   reg_nib = ~b_mfg[b][15:12];
      8'h09:   reg_nib = ~b_mfg[b][11:8];
      8'h0A:   reg_nib = ~b_mfg[b][7:4];
      8'h0B:   reg_nib = ~b_mfg[b][3:0];
      default: reg_nib = 4'h0;
    endcase
  endfunction

  bit in_cyc = 0, adv = 0;
  int dly = 0;
  always @(negedge CLK) begin
    if (clr_seen != clr_req) begin
      clr_seen = clr_req;
      board_ptr = 0;
      wlog_reg.delete();
      wlog_dat.delete();
    end
    if (ASn) begin
      if (in_cyc && adv) board_ptr++;
      in_cyc = 0;
      adv = 0;
      DTACKn = 1'b1;
    end else begin
      if (!in_cyc) begin
        in_cyc = 1;
        dly = $urandom_range(0, 3);
      end
      if (!hold_off && board_ptr < nb && DTACKn) begin
        if (dly > 0) dly--;
        else begin
          DTACKn = 1'b0;
          DBUS_IN = reg_nib(board_ptr, ADDR[7:0]);
          check("addr_hi", 32'(ADDR[22:8]), 32'h7400);
          check("lds_high", 32'(LDSn), 32'd1);
          if (!RWn) begin
            check("wr_oe", 32'(DBUS_OE), 32'd1);
            wlog_reg.push_back(ADDR[7:0]);
            wlog_dat.push_back(DBUS_OUT);
            if (ADDR[7:0] == 8'h24 || ADDR[7:0] == 8'h26) adv = 1;
          end
        end
      end
    end
  end

  // Reference placement, stated directly from the allocation rules.
  int exp_n;
  int exp_base[16];
  bit exp_shut[16];

  function automatic int mb_of(input logic [2:0] c);
    case (c)
      3'b000:  mb_of = 8;
      3'b111:  mb_of = 4;
      3'b110:  mb_of = 2;
      3'b101:  mb_of = 1;
      default: mb_of = 0;
    endcase
  endfunction

  task automatic build_model();
    int nf, s, a, b;
    exp_n = (nb < 8) ? nb : 8;
    nf = 2;
    for (int i = 0; i < exp_n; i++) begin
      s = mb_of(b_size[i]);
      exp_shut[i] = 1;
      exp_base[i] = 0;
      if (b_type[i][3:2] == 2'b11 && b_type[i][1] && s > 0) begin
        a = (s >= 2) ? 2 : 1;
        b = 2 + ((nf - 2 + a - 1) / a) * a;
        if (b + s <= 10) begin
          exp_base[i] = b;
          exp_shut[i] = 0;
          nf = b + s;
        end
      end
    end
  endtask

  task automatic set_board(input int i, input logic [3:0] t, input logic [2:0] s);
    b_type[i] = t;
    b_size[i] = s;
    b_s3[i]   = 1'($urandom_range(0, 1));
    b_prod[i] = 8'($urandom);
    b_mfg[i]  = 16'($urandom);
  endtask

  task automatic begin_run();
    clr_req = ~clr_req;
    repeat (2) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic run_enum(input int ready_hold);
    int nrep, cyc;
    bit fin, need_wait;
    build_model();
    begin_run();
    check("busy_start", 32'(busy), 32'd1);
    nrep = 0; cyc = 0; fin = 0; need_wait = 0;
    while (!fin) begin
      if (need_wait) @(negedge CLK);
      need_wait = 1;
      cyc++;
      if (cyc > 3000) begin
        check("enum_bound", 32'(done), 32'd1);
        fin = 1;
      end else if (done) begin
        check("done_no_rpt", 32'(rpt_valid), 32'd0);
        check("rpt_count", 32'(nrep), 32'(exp_n));
        check("board_count", 32'(board_count), 32'(exp_n));
        @(negedge CLK);
        check("done_pulse", {30'd0, done, busy}, 32'd0);
        fin = 1;
      end else if (rpt_valid) begin
        if (nrep >= exp_n) begin
          check("extra_rpt", 32'(nrep), 32'(exp_n));
        end else begin
          check("rpt_base", 32'(rpt_base), 32'(exp_base[nrep]));
          check("rpt_shutup", 32'(rpt_shutup), 32'(exp_shut[nrep]));
          check("rpt_size", 32'(rpt_size), 32'(b_size[nrep]));
          check("rpt_busy", 32'(busy), 32'd1);
`ifdef AUTOCFG_ID_READ_EN
          check("rpt_prod", 32'(rpt_prod), 32'(b_prod[nrep]));
          check("rpt_mfg", 32'(rpt_mfg), 32'(b_mfg[nrep]));
`endif
          for (int h = 0; h < ready_hold; h++) begin
            start = (h == 2);
            @(negedge CLK);
            check("hold_stable", {21'd0, rpt_valid, rpt_base, rpt_size, rpt_shutup, ASn, DBUS_OE},
                  {21'd0, 1'b1, 4'(exp_base[nrep]), b_size[nrep], exp_shut[nrep], 1'b1, 1'b0});
          end
          start = 1'b0;
        end
        rpt_ready = 1'b1;
        @(negedge CLK);
        rpt_ready = 1'b0;
        nrep++;
        need_wait = 0;
      end
    end
    check("wlog_len", 32'(wlog_reg.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wlog_reg.size(); i++) begin
      check("wr_reg", 32'(wlog_reg[i]), exp_shut[i] ? 32'h26 : 32'h24);
      check("wr_data", 32'(wlog_dat[i]), 32'(exp_base[i]));
    end
  endtask

  initial begin
    int cyc;
    RESETn = 1'b0; start = 1'b0; rpt_ready = 1'b0; hold_off = 1'b0; clr_req = 1'b0; nb = 0;
    repeat (3) @(negedge CLK);
    check("rst_strobes", {28'd0, ASn, UDSn, LDSn, RWn}, 32'hF);
    check("rst_oe", 32'(DBUS_OE), 32'd0);
    check("rst_addr", 32'(ADDR), 32'd0);
    check("rst_status", {29'd0, busy, done, rpt_valid}, 32'd0);
    check("rst_count", 32'(board_count), 32'd0);
    RESETn = 1'b1;

    // one 8MB board
    nb = 1; set_board(0, 4'hE, 3'b000);
    run_enum(0);
    // 4MB, 2MB, 2MB: bases 2, 6, then next_free 8
    nb = 3; set_board(0, 4'hE, 3'b111); set_board(1, 4'hE, 3'b110); set_board(2, 4'hE, 3'b110);
    run_enum(10);
    // 4MB, 4MB, 1MB: third does not fit
    nb = 3; set_board(0, 4'hE, 3'b111); set_board(1, 4'hF, 3'b111); set_board(2, 4'hE, 3'b101);
    run_enum(0);
    // non-memory board, then 4MB still at base 2
    nb = 2; set_board(0, 4'hC, 3'b111); set_board(1, 4'hE, 3'b111);
    run_enum(0);
    // nine 1MB boards: stop after eight
    nb = 9;
    for (int i = 0; i < 9; i++) set_board(i, 4'hE, 3'b101);
    run_enum(0);
    // random chains
    for (int r = 0; r < 15; r++) begin
      nb = $urandom_range(0, 10);
      for (int i = 0; i < nb; i++) begin
        logic [2:0] sc;
        logic [3:0] tn;
        case ($urandom_range(0, 4))
          0: sc = 3'b000; 1: sc = 3'b111; 2: sc = 3'b110; 3: sc = 3'b101;
          default: sc = 3'($urandom);
        endcase
        tn = ($urandom_range(0, 3) != 0) ? {3'b111, 1'($urandom)} : 4'($urandom);
        set_board(i, tn, sc);
      end
      run_enum((r % 4 == 0) ? 3 : 0);
    end

    // reset in the middle of a bus cycle
    nb = 2; set_board(0, 4'hE, 3'b111); set_board(1, 4'hE, 3'b111);
    begin_run();
    cyc = 0;
    while (!rpt_valid && cyc < 500) begin @(negedge CLK); cyc++; end
    check("mr_rpt", 32'(rpt_valid), 32'd1);
    hold_off = 1'b1;
    rpt_ready = 1'b1;
    @(negedge CLK);
    rpt_ready = 1'b0;
    cyc = 0;
    while (ASn && cyc < 50) begin @(negedge CLK); cyc++; end
    check("mr_as_low", 32'(ASn), 32'd0);
    repeat (2) @(negedge CLK);
    check("mr_pre_count", 32'(board_count), 32'd1);
    RESETn = 1'b0;
    @(negedge CLK);
    check("mr_strobes", {29'd0, ASn, UDSn, DBUS_OE}, 32'h6);
    check("mr_status", {29'd0, busy, done, rpt_valid}, 32'd0);
    check("mr_count", 32'(board_count), 32'd0);
    check("mr_addr", 32'(ADDR), 32'd0);
    RESETn = 1'b1;
    hold_off = 1'b0;
    repeat (2) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z2_autoconfig_host.md
Name: z2_autoconfig_host

Overview:
Zorro II autoconfig initiator: the host end of the Zorro II autoconfig protocol, used as a bench/bring-up master and in host-side glue. It runs 68000-style nibble bus cycles in $E8xxxx, reads each board's type and size, and allocates 1-8MB memory boards into the $200000-$9FFFFF window. It writes the base nibble to each board, or tells it to shut up, and repeats until no board answers.

Parameters:
FREE_BASE, 4'h2, first A23:20 nibble of the allocation window
FREE_END, 4'hA, exclusive end nibble of the window
TIMEOUT, 64, CLK cycles to wait for DTACKn before declaring no board present
MAX_BOARDS, 8, enumeration stops after this many boards

Ports:
CLK  in  1  system clock; all logic on posedge
RESETn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins enumeration when idle
ADDR  out  23  bus address A23:1
DBUS_OUT  out  4  write data D15:12
DBUS_OE  out  1  drive DBUS_OUT onto the bus
DBUS_IN  in  4  read data D15:12
ASn, UDSn, LDSn, RWn  out  1 each  68000 bus strobes
DTACKn  in  1  board acknowledge (active low)
busy  out  1  enumeration in progress
done  out  1  pulse, one cycle, at end of enumeration
rpt_valid  out  1  board report available
rpt_ready  in  1  consumer accepts report
rpt_base  out  4  assigned A23:20 nibble (0 if shut up)
rpt_size  out  3  raw er_Type size code
rpt_shutup  out  1  board was told to shut up
board_count  out  4  boards processed so far

Behaviour:
- Reset (next posedge with RESETn low, including mid-cycle):
  - ASn=UDSn=LDSn=RWn=1, DBUS_OE=0, ADDR=0.
  - busy=done=rpt_valid=0, board_count=0, next_free=FREE_BASE, FSM=IDLE.
- Bus cycle engine:
  - SETUP (1 clk): ADDR={8'hE8,7'b0,reg[7:0]}; RWn set; for writes, DBUS_OE=1 with data.
  - STROBE: ASn=UDSn=0; LDSn stays 1.
  - WAIT: DTACKn is sampled each clk. On DTACKn=0, DBUS_IN is latched (reads) at that edge.
  - RELEASE (1 clk): ASn=UDSn=1, RWn=1, DBUS_OE=0. DBUS_OE drops in the same cycle.
  - A cycle counting TIMEOUT clks without DTACK aborts the cycle (RELEASE) and flags a timeout.
- Enumeration FSM: IDLE -> RD_TYPE(reg 00) -> RD_SIZE(reg 01) -> [RD_ID] -> ALLOC -> WR_BASE(reg 24) | WR_SHUT(reg 26) -> REPORT -> RD_TYPE ...
- RD_TYPE timeout -> FIN. FIN pulses done, clears busy, returns to IDLE.
- Board validity: type nibble [3:2] must be 11 (Zorro II) and bit1 must be 1 (memory). Otherwise -> WR_SHUT.
- Size code mapping: 000=8MB, 111=4MB, 110=2MB, 101=1MB. Any other code -> WR_SHUT.
- ALLOC:
  - align = min(S,2)MB; base = next_free rounded up to align relative to FREE_BASE.
  - If base+S <= FREE_END: write base nibble, next_free = base+S. Otherwise -> WR_SHUT.
  - 5-bit arithmetic, so no wrap at 4'hF.
- REPORT: rpt_valid held with stable fields until rpt_ready=1. Handshake occurs on a clk where both are 1; board_count increments then.
- After the handshake: board_count==MAX_BOARDS -> FIN, else RD_TYPE.
- start while busy is ignored. rpt_valid and done are never high together.

Optional Feature:
- Macro: AUTOCFG_ID_READ_EN.
- Defined:
  - RD_ID reads regs 02,03 (product) and 08-0B (manufacturer), each inverted on capture.
  - Adds outputs rpt_prod[7:0] and rpt_mfg[15:0], valid with rpt_valid.
- Undefined: RD_ID is skipped (RD_SIZE -> ALLOC directly) and those ports are absent.

Decomposition:
- Package z2_autoconfig_pkg:
  - Register index constants: REG_TYPE=8'h00, REG_SIZE=8'h01, REG_BASE=8'h24, REG_SHUTUP=8'h26, ID regs.
  - Size-code enum and a size-code-to-MB function.
  - FSM state typedef.
- Sub-module z2_bus_cycle: the SETUP/STROBE/WAIT/RELEASE engine with timeout. Interface: req, rw, reg, wdata -> ack, rdata, timeout.

Test Plan:
- One board: type E, size 0; second RD_TYPE gets no DTACK -> write reg24=2, report base 2 size 000, done, board_count=1.
- Boards 4MB(111) then 2MB(110) -> bases 2 then 6, next_free=8.
- Boards 4MB, 4MB, 1MB -> bases 2, 6, third gets reg26 write, rpt_shutup=1, base 0.
- Type nibble 0xC (non-memory) -> reg26 write, no base write, next_free unchanged.
- rpt_ready held low 10 clks -> rpt_valid and fields stable, no bus activity until ready.
- RESETn low while ASn=0 in WAIT -> next clk ASn=UDSn=1, DBUS_OE=0, busy=0, board_count=0.
